data_ram_arbiter: RTL

- Shares the single-port data RAM between two requesters: port A (processor load/store stage) and port B (I/O / DMA transfer engine).
- Arbitrates round-robin, sequences one RAM access at a time and drives the RAM address, write data and write enable.
- Captures RAM read data after a fixed read latency and returns it with a one-cycle acknowledge.
- Rejects addresses beyond the physical RAM depth without touching the RAM.

---
 rtl/data_ram_arbiter_if.sv | 49 ++++
 rtl/data_ram_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter_if.sv
// data_ram_arbiter_if
//    Request/acknowledge bundle for the two requesters of the data RAM
//    arbiter: port A (load/store stage) and port B (I/O / DMA engine).
//
//    Per port x in {a, b}:
//       req_x    request, held with we/addr/wdata until ack
//       we_x     1 = write, 0 = read
//       addr_x   word address
//       wdata_x  write data
//       ack_x    one-cycle completion pulse
//       err_x    qualifies ack_x: address out of range
//       rdata_x  read result, valid with ack_x and held until the next ack_x
//
//    Modports: master = requester side, slave = arbiter side.
//    ADDR_WIDTH/DATA_WIDTH must match the arbiter instance it is attached to.
interface data_ram_arbiter_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) ();
   logic                  req_a;
   logic                  we_a;
   logic [ADDR_WIDTH-1:0] addr_a;
   logic [DATA_WIDTH-1:0] wdata_a;
   logic                  ack_a;
   logic                  err_a;
   logic [DATA_WIDTH-1:0] rdata_a;

   logic                  req_b;
   logic                  we_b;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic [DATA_WIDTH-1:0] wdata_b;
   logic                  ack_b;
   logic                  err_b;
   logic [DATA_WIDTH-1:0] rdata_b;

   modport master (
      output req_a, we_a, addr_a, wdata_a,
      output req_b, we_b, addr_b, wdata_b,
      input  ack_a, err_a, rdata_a,
      input  ack_b, err_b, rdata_b
   );

   modport slave (
      input  req_a, we_a, addr_a, wdata_a,
      input  req_b, we_b, addr_b, wdata_b,
      output ack_a, err_a, rdata_a,
      output ack_b, err_b, rdata_b
   );
endinterface

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//    Shares one single-port data RAM between two requesters with round-robin
//    arbitration, one access at a time. Addresses at or beyond DEPTH are
//    answered with err and never reach the RAM.
//
//    Ports:
//       clock            system clock, everything on posedge
//       reset            synchronous active-high reset
//       bus              data_ram_arbiter_if.slave, requester ports A and B
//       busy             high whenever the sequencer is not idle
//       ram_address      RAM word address
//       ram_data         RAM write data
//       ram_write_enable RAM write strobe (one cycle per valid write)
//       ram_read_data    RAM read output, valid READ_LATENCY cycles after
//                        the address is presented
//
//    Sequence: IDLE -> ACCESS -> (WAIT x READ_LATENCY for reads) -> RESPOND,
//    or IDLE -> RESPOND directly for an out-of-range address.
//    Latency from the sampling edge: error 1, write 2, read 2+READ_LATENCY.
module data_ram_arbiter #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 271,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   data_ram_arbiter_if.slave     bus,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_write_enable,
   input  logic [DATA_WIDTH-1:0] ram_read_data
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESPOND} state_t;

   // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
   // WAIT lasts READ_LATENCY cycles; the counter runs down to zero.
   localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

   state_t                state_reg;
   logic                  grant_b_reg;       // port currently being served
   logic                  last_grant_b_reg;  // port served most recently
   logic                  we_reg;
   logic [1:0]            wait_cnt_reg;
   logic                  busy_reg;
   logic                  ack_a_reg, ack_b_reg;
   logic                  err_a_reg, err_b_reg;
   logic [DATA_WIDTH-1:0] rdata_a_reg, rdata_b_reg;
   logic [ADDR_WIDTH-1:0] ram_address_reg;
   logic [DATA_WIDTH-1:0] ram_data_reg;
   logic                  ram_we_reg;

   logic                  sel_b;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  sel_err;

   // Arbitration: a lone requester wins; on a tie the port that was not
   // served last wins.
   always_comb begin
      sel_b     = bus.req_b && (!bus.req_a || !last_grant_b_reg);
      sel_we    = sel_b ? bus.we_b    : bus.we_a;
      sel_addr  = sel_b ? bus.addr_b  : bus.addr_a;
      sel_wdata = sel_b ? bus.wdata_b : bus.wdata_a;
      sel_err   = {1'b0, sel_addr} >= DEPTH_LIM;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         grant_b_reg      <= 1'b0;
         last_grant_b_reg <= 1'b1;
         we_reg           <= 1'b0;
         wait_cnt_reg     <= 2'd0;
         busy_reg         <= 1'b0;
         ack_a_reg        <= 1'b0;
         ack_b_reg        <= 1'b0;
         err_a_reg        <= 1'b0;
         err_b_reg        <= 1'b0;
         rdata_a_reg      <= '0;
         rdata_b_reg      <= '0;
         ram_address_reg  <= '0;
         ram_data_reg     <= '0;
         ram_we_reg       <= 1'b0;
      end else begin
         // Pulses default low; set only on the transition that needs them.
         ack_a_reg  <= 1'b0;
         ack_b_reg  <= 1'b0;
         err_a_reg  <= 1'b0;
         err_b_reg  <= 1'b0;
         ram_we_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (bus.req_a || bus.req_b) begin
                  grant_b_reg      <= sel_b;
                  last_grant_b_reg <= sel_b;
                  we_reg           <= sel_we;
                  busy_reg         <= 1'b1;
                  if (sel_err) begin
                     // Skip the RAM entirely; a rejected read returns zero.
                     state_reg <= ST_RESPOND;
                     if (sel_b) begin
                        ack_b_reg <= 1'b1;
                        err_b_reg <= 1'b1;
                        if (!sel_we) rdata_b_reg <= '0;
                     end else begin
                        ack_a_reg <= 1'b1;
                        err_a_reg <= 1'b1;
                        if (!sel_we) rdata_a_reg <= '0;
                     end
                  end else begin
                     // Registered RAM drive so it is valid during ACCESS.
                     state_reg       <= ST_ACCESS;
                     ram_address_reg <= sel_addr;
                     ram_data_reg    <= sel_wdata;
                     ram_we_reg      <= sel_we;
                  end
               end
            end
            ST_ACCESS: begin
               if (we_reg) begin
                  state_reg <= ST_RESPOND;
                  if (grant_b_reg) ack_b_reg <= 1'b1;
                  else             ack_a_reg <= 1'b1;
               end else begin
                  state_reg    <= ST_WAIT;
                  wait_cnt_reg <= WAIT_INIT;
               end
            end
            ST_WAIT: begin
               // ram_address_reg is untouched here, so the address stays
               // stable for the whole read pipeline.
               if (wait_cnt_reg == 2'd0) begin
                  state_reg <= ST_RESPOND;
                  if (grant_b_reg) begin
                     rdata_b_reg <= ram_read_data;
                     ack_b_reg   <= 1'b1;
                  end else begin
                     rdata_a_reg <= ram_read_data;
                     ack_a_reg   <= 1'b1;
                  end
               end else begin
                  wait_cnt_reg <= wait_cnt_reg - 2'd1;
               end
            end
            ST_RESPOND: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.ack_a        = ack_a_reg;
   assign bus.ack_b        = ack_b_reg;
   assign bus.err_a        = err_a_reg;
   assign bus.err_b        = err_b_reg;
   assign bus.rdata_a      = rdata_a_reg;
   assign bus.rdata_b      = rdata_b_reg;
   assign busy             = busy_reg;
   assign ram_address      = ram_address_reg;
   assign ram_data         = ram_data_reg;
   assign ram_write_enable = ram_we_reg;

endmodule
